// File: rtl/control_status_register_file.sv
// -----------------------------------------------------------------------------
// control_status_register_file
//
// Machine CSR file with a Zicsr read-modify-write engine. It executes
// CSRRW/CSRRS/CSRRC and their immediate forms behind a valid/ready handshake.
// It also keeps the 64-bit cycle and retired-instruction counters.
//
// Each request is accepted in IDLE. The CSR write commits at that same edge.
// The response (old value plus illegal flag) is presented for exactly one
// cycle in RESPOND. The block then returns to IDLE, so it can take at most one
// request every two cycles.
//
// Optional feature (define the macro CSR_COUNTER_INHIBIT_EN):
//   Adds mcountinhibit at 0x320. Bit 0 (CY) freezes mcycle and bit 2 (IR)
//   freezes minstret. When the macro is not defined, 0x320 is unimplemented.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   csr_valid      request strobe
//   csr_ready      block can accept a request this cycle
//   funct3         Zicsr operation encoding
//   csr_address    12-bit CSR address
//   rs1            register operand (XLEN)
//   rs1_index      rs1 field / uimm for the immediate forms
//   instret_pulse  one instruction retired this cycle
//   csr_done       one-cycle response strobe
//   rd_value       CSR value before the update (0 on a fault)
//   illegal_access request faulted, qualified by csr_done
// -----------------------------------------------------------------------------
module control_status_register_file #(
  parameter int XLEN          = 32,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_SCRATCH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_valid,
  output logic            csr_ready,
  input  logic [2:0]      funct3,
  input  logic [11:0]     csr_address,
  input  logic [XLEN-1:0] rs1,
  input  logic [4:0]      rs1_index,
  input  logic            instret_pulse,
  output logic            csr_done,
  output logic [XLEN-1:0] rd_value,
  output logic            illegal_access
);

  localparam int HI_W = COUNTER_WIDTH - XLEN;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  typedef enum logic {IDLE, RESPOND} state_t;

  state_t                   state;
  logic [XLEN-1:0]          mscratch;
  logic [XLEN-1:0]          scratch [NUM_SCRATCH];
  logic [COUNTER_WIDTH-1:0] mcycle;
  logic [COUNTER_WIDTH-1:0] minstret;
  logic [XLEN-1:0]          rd_value_q;
  logic                     illegal_q;
  logic                     inhibit_cy;
  logic                     inhibit_ir;

  // Decode and read-modify-write datapath
  logic                     accept;
  logic                     implemented;
  logic                     write_req;
  logic                     fault;
  logic                     do_write;
  logic [XLEN-1:0]          old_value;
  logic [XLEN-1:0]          operand;
  logic [XLEN-1:0]          new_value;
  logic                     scratch_hit;
  logic [NUM_SCRATCH-1:0]   wr_scratch;

  assign accept = (state == IDLE) && csr_valid;

  // A CSRRW always writes. The set/clear forms write only when rs1 or uimm is
  // nonzero. This lets software read a read-only CSR with CSRRS x0.
  assign write_req = (funct3[1:0] == 2'b01) || (rs1_index != 5'd0);
  assign operand   = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_index} : rs1;

  // NOTE: every signal written in this block gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    implemented = 1'b0;
    old_value   = '0;
    scratch_hit = 1'b0;
    wr_scratch  = '0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (csr_address == 12'h7C0 + 12'(i)) begin
        scratch_hit = 1'b1;
        old_value   = scratch[i];
      end
    end
    case (csr_address)
      12'h340: begin
        implemented = 1'b1;
        old_value   = mscratch;
      end
      12'hB00, 12'hC00: begin
        implemented = 1'b1;
        old_value   = mcycle[XLEN-1:0];
      end
      12'hB80, 12'hC80: begin
        implemented = 1'b1;
        old_value   = XLEN'(mcycle[COUNTER_WIDTH-1:XLEN]);
      end
      12'hB02, 12'hC02: begin
        implemented = 1'b1;
        old_value   = minstret[XLEN-1:0];
      end
      12'hB82, 12'hC82: begin
        implemented = 1'b1;
        old_value   = XLEN'(minstret[COUNTER_WIDTH-1:XLEN]);
      end
`ifdef CSR_COUNTER_INHIBIT_EN
      12'h320: begin
        implemented = 1'b1;
        old_value   = {{(XLEN-3){1'b0}}, inhibit_ir, 1'b0, inhibit_cy};
      end
`endif
      default: implemented = scratch_hit;
    endcase

    case (funct3[1:0])
      2'b01:   new_value = operand;
      2'b10:   new_value = old_value | operand;
      2'b11:   new_value = old_value & ~operand;
      default: new_value = old_value;
    endcase

    fault = !implemented || (funct3[1:0] == 2'b00) ||
            (write_req && (csr_address[11:10] == 2'b11));
    do_write = accept && write_req && !fault;

    for (int i = 0; i < NUM_SCRATCH; i++) begin
      wr_scratch[i] = do_write && (csr_address == 12'h7C0 + 12'(i));
    end
  end

  logic wr_mscratch, wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
  assign wr_mscratch = do_write && (csr_address == 12'h340);
  assign wr_cyc_lo   = do_write && (csr_address == 12'hB00);
  assign wr_cyc_hi   = do_write && (csr_address == 12'hB80);
  assign wr_ins_lo   = do_write && (csr_address == 12'hB02);
  assign wr_ins_hi   = do_write && (csr_address == 12'hB82);

  // Handshake FSM and response registers
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rd_value_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (csr_valid) begin
            state      <= RESPOND;
            rd_value_q <= fault ? '0 : old_value;
            illegal_q  <= fault;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs come straight from the state register, so they are glitch-free.
  assign csr_ready      = (state == IDLE);
  assign csr_done       = (state == RESPOND);
  assign rd_value       = rd_value_q;
  assign illegal_access = illegal_q;

  // Scratch storage
  // NOTE: the scratch array is reset along with the other CSRs. It is a few
  // flops, not a RAM, so clearing it costs nothing special.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mscratch <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      if (wr_mscratch) mscratch <= new_value;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (wr_scratch[i]) scratch[i] <= new_value;
      end
    end
  end

  // Counter inhibit (optional)
`ifdef CSR_COUNTER_INHIBIT_EN
  logic wr_inhibit;
  assign wr_inhibit = do_write && (csr_address == 12'h320);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inhibit_cy <= 1'b0;
      inhibit_ir <= 1'b0;
    end else if (wr_inhibit) begin
      inhibit_cy <= new_value[0];
      inhibit_ir <= new_value[2];
    end
  end
`else
  assign inhibit_cy = 1'b0;
  assign inhibit_ir = 1'b0;
`endif

  // Counters: an explicit write to either half beats that cycle's increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr_cyc_lo)       mcycle[XLEN-1:0]          <= new_value;
      else if (wr_cyc_hi)  mcycle[COUNTER_WIDTH-1:XLEN] <= new_value[HI_W-1:0];
      else if (!inhibit_cy) mcycle                   <= mcycle + CNT_ONE;

      if (wr_ins_lo)       minstret[XLEN-1:0]          <= new_value;
      else if (wr_ins_hi)  minstret[COUNTER_WIDTH-1:XLEN] <= new_value[HI_W-1:0];
      else if (instret_pulse && !inhibit_ir) minstret  <= minstret + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_control_status_register_file.sv
// -----------------------------------------------------------------------------
// tb_control_status_register_file
//
// Directed scoreboard bench. The driver pushes the hand-computed response for
// each request into a queue. A monitor pops that entry and compares it
// whenever csr_done is seen. The monitor also checks that csr_done lasts one
// cycle and that csr_ready is low while a response is presented.
// -----------------------------------------------------------------------------
module tb_control_status_register_file;

  localparam logic [2:0] F_RW  = 3'b001, F_RS  = 3'b010, F_RC  = 3'b011;
  localparam logic [2:0] F_RWI = 3'b101, F_RSI = 3'b110, F_RCI = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        csr_valid = 1'b0;
  logic        csr_ready;
  logic [2:0]  funct3 = '0;
  logic [11:0] csr_address = '0;
  logic [31:0] rs1 = '0;
  logic [4:0]  rs1_index = '0;
  logic        instret_pulse = 1'b0;
  logic        csr_done;
  logic [31:0] rd_value;
  logic        illegal_access;

  control_status_register_file dut (
    .clk            (clk),
    .reset          (reset),
    .csr_valid      (csr_valid),
    .csr_ready      (csr_ready),
    .funct3         (funct3),
    .csr_address    (csr_address),
    .rs1            (rs1),
    .rs1_index      (rs1_index),
    .instret_pulse  (instret_pulse),
    .csr_done       (csr_done),
    .rd_value       (rd_value),
    .illegal_access (illegal_access)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        ill;
    bit          care_rd;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive one request in IDLE. It is accepted at the next rising edge, and
  // the bench waits out the RESPOND cycle.
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] r, input logic [4:0] idx,
                       input logic [31:0] exp_rd, input logic exp_ill,
                       input bit care_rd, input string name);
    exp_t e;
    @(negedge clk);
    check({name, "_ready"}, csr_ready, 1'b1);
    funct3      = f3;
    csr_address = addr;
    rs1         = r;
    rs1_index   = idx;
    csr_valid   = 1'b1;
    e.rd = exp_rd; e.ill = exp_ill; e.care_rd = care_rd; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1 csr_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: sample away from the rising edge
  always @(negedge clk) begin
    if (csr_done) begin
      check("done_width", prev_done, 1'b0);
      check("ready_in_respond", csr_ready, 1'b0);
      if (sb.size() == 0) begin
        check("unexpected_done", csr_done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_illegal"}, illegal_access, e.ill);
        if (e.care_rd) check({e.name, "_rd"}, rd_value, e.rd);
      end
    end
    prev_done = csr_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_done", csr_done, 1'b0);
    check("reset_ready", csr_ready, 1'b1);
    check("reset_rd", rd_value, 32'h0);
    check("reset_ill", illegal_access, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    // mscratch write, then a non-writing set
    issue(F_RW, 12'h340, 32'hDEADBEEF, 5'd1, 32'h0, 1'b0, 1, "mscratch_rw");
    issue(F_RS, 12'h340, 32'hFFFFFFFF, 5'd0, 32'hDEADBEEF, 1'b0, 1, "mscratch_rs0");
    issue(F_RS, 12'h340, 32'h0, 5'd0, 32'hDEADBEEF, 1'b0, 1, "mscratch_nowrite");

    // scratch immediate forms and bounds
    issue(F_RSI, 12'h7C1, 32'h0, 5'd5, 32'h0, 1'b0, 1, "scr1_rsi");
    issue(F_RCI, 12'h7C1, 32'h0, 5'd1, 32'h5, 1'b0, 1, "scr1_rci");
    issue(F_RS,  12'h7C1, 32'h0, 5'd0, 32'h4, 1'b0, 1, "scr1_read");
    issue(F_RW,  12'h7C3, 32'h12345678, 5'd2, 32'h0, 1'b0, 1, "scr3_rw");
    issue(F_RS,  12'h7C3, 32'h0, 5'd0, 32'h12345678, 1'b0, 1, "scr3_read");
    issue(F_RW,  12'h7C4, 32'h1, 5'd2, 32'h0, 1'b1, 1, "scr4_illegal");

    // minstret write wins over a simultaneous pulse
    instret_pulse = 1'b1;
    issue(F_RW, 12'hB02, 32'd100, 5'd1, 32'h0, 1'b0, 1, "minstret_rw");
    instret_pulse = 1'b0;
    issue(F_RS, 12'hB02, 32'h0, 5'd0, 32'd101, 1'b0, 1, "minstret_read");
    issue(F_RS, 12'hC82, 32'h0, 5'd0, 32'h0, 1'b0, 1, "instreth_read");

    // mcycle wrap through zero
    issue(F_RW, 12'hB00, 32'hFFFFFFFE, 5'd1, 32'h0, 1'b0, 0, "mcycle_lo_rw");
    issue(F_RW, 12'hB80, 32'hFFFFFFFF, 5'd1, 32'h0, 1'b0, 1, "mcycle_hi_rw");
    issue(F_RS, 12'hC80, 32'h0, 5'd0, 32'h0, 1'b0, 1, "cycleh_wrapped");
    issue(F_RS, 12'hC00, 32'h0, 5'd0, 32'd2, 1'b0, 1, "cycle_wrapped");
    issue(F_RW, 12'hC00, 32'h0, 5'd3, 32'h0, 1'b1, 1, "cycle_write_ill");
    issue(F_RS, 12'hC00, 32'h0, 5'd0, 32'd6, 1'b0, 1, "cycle_unaffected");

    // illegal cases
    issue(F_RS, 12'hC00, 32'h0, 5'd1, 32'h0, 1'b1, 1, "cycle_rs_nz_ill");
    issue(F_RS, 12'h123, 32'h0, 5'd0, 32'h0, 1'b1, 1, "unimpl_ill");
    issue(3'b000, 12'h340, 32'h0, 5'd0, 32'h0, 1'b1, 1, "f3_000_ill");
    issue(3'b100, 12'h340, 32'h0, 5'd0, 32'h0, 1'b1, 1, "f3_100_ill");
    issue(F_RC, 12'hC02, 32'h0, 5'd0, 32'd101, 1'b0, 1, "instret_alias");

`ifdef CSR_COUNTER_INHIBIT_EN
    issue(F_RW, 12'h320, 32'hFFFFFFFF, 5'd1, 32'h0, 1'b0, 1, "inhibit_all");
    issue(F_RW, 12'h320, 32'h5, 5'd1, 32'h5, 1'b0, 1, "inhibit_mask");
    instret_pulse = 1'b1;
    issue(F_RW, 12'hB00, 32'd1000, 5'd1, 32'h0, 1'b0, 0, "frozen_cyc_wr");
    issue(F_RW, 12'hB02, 32'd50, 5'd1, 32'd101, 1'b0, 1, "frozen_ins_wr");
    repeat (10) @(posedge clk);
    #1;
    issue(F_RS, 12'hB00, 32'h0, 5'd0, 32'd1000, 1'b0, 1, "frozen_cyc");
    issue(F_RS, 12'hB02, 32'h0, 5'd0, 32'd50, 1'b0, 1, "frozen_ins");
    issue(F_RW, 12'h320, 32'h0, 5'd0, 32'h5, 1'b0, 1, "inhibit_clear");
    instret_pulse = 1'b0;
    issue(F_RS, 12'hB00, 32'h0, 5'd0, 32'd1001, 1'b0, 1, "resumed_cyc");
    issue(F_RS, 12'hB02, 32'h0, 5'd0, 32'd51, 1'b0, 1, "resumed_ins");
`else
    issue(F_RS, 12'h320, 32'h0, 5'd0, 32'h0, 1'b1, 1, "inhibit_absent");
`endif

    // reset while RESPOND is active drops the response
    @(negedge clk);
    funct3 = F_RW; csr_address = 12'h340; rs1 = 32'h55; rs1_index = 5'd1;
    csr_valid = 1'b1;
    @(posedge clk);
    #1 csr_valid = 1'b0;
    reset = 1'b0;
    #1 check("reset_mid_done", csr_done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    issue(F_RS, 12'h340, 32'h0, 5'd0, 32'h0, 1'b0, 1, "post_rst_mscratch");
    issue(F_RS, 12'h7C1, 32'h0, 5'd0, 32'h0, 1'b0, 1, "post_rst_scratch");
    issue(F_RS, 12'hB02, 32'h0, 5'd0, 32'h0, 1'b0, 1, "post_rst_minstret");
    issue(F_RS, 12'hB82, 32'h0, 5'd0, 32'h0, 1'b0, 1, "post_rst_minstreth");
`ifdef CSR_COUNTER_INHIBIT_EN
    issue(F_RS, 12'h320, 32'h0, 5'd0, 32'h0, 1'b0, 1, "post_rst_inhibit");
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/control_status_register_file.md
Name: control_status_register_file

Overview:
- Parametrised, stateful successor to the combinational CSR operand unit.
- Holds the machine CSRs and executes all six Zicsr operations (CSRRW/S/C, CSRRWI/SI/CI) as a read-modify-write with a valid/ready handshake.
- Maintains 64-bit cycle and retired-instruction counters and flags illegal accesses.
- Sits beside the execute stage; the core stalls while csr_ready is low.

Parameters:
- XLEN, 32, data width of rs1, rd_value and each CSR half.
- COUNTER_WIDTH, 64, width of the cycle/instret counters; legal range XLEN+1 .. 2*XLEN, zero-extended to 2*XLEN when read.
- NUM_SCRATCH, 4, number of custom scratch CSRs at 0x7C0 .. 0x7C0+NUM_SCRATCH-1; legal range 1..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- csr_valid  input  1  request strobe.
- csr_ready  output  1  block can accept a request this cycle.
- funct3  input  3  Zicsr operation encoding.
- csr_address  input  12  CSR address.
- rs1  input  XLEN  source register value.
- rs1_index  input  5  rs1 field; equals the uimm field for the I-forms.
- instret_pulse  input  1  one instruction retired this cycle.
- csr_done  output  1  response valid, one cycle wide.
- rd_value  output  XLEN  old CSR value.
- illegal_access  output  1  request faulted; qualified by csr_done.

Behaviour:
- FSM has two states: IDLE and RESPOND.
  - IDLE: csr_ready=1. If csr_valid=1, the request is accepted at the clock edge and the FSM moves to RESPOND.
  - RESPOND: csr_ready=0, csr_done=1, rd_value and illegal_access are driven from registers. The FSM always returns to IDLE. csr_valid is ignored in RESPOND.
- Latency: the response appears exactly 1 cycle after acceptance. Peak throughput is one request every 2 cycles.
- Read value: rd_value is the CSR value before the update, sampled in the accept cycle.
- Operand: op = rs1 for the register forms (funct3[2]=0), or {zeros, rs1_index} for the I-forms.
- New value:
  - RW: op.
  - RS: old | op.
  - RC: old & ~op.
- Write suppression: RS/RC/RSI/RCI with rs1_index==0 perform no write and never fault on write. RW/RWI always write, including when rs1_index==0.
- Implemented CSRs:
  - mscratch 0x340, RW.
  - scratch[i] 0x7C0+i, RW.
  - mcycle/mcycleh 0xB00/0xB80, RW.
  - minstret/minstreth 0xB02/0xB82, RW.
  - cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82, read-only aliases.
- illegal_access=1 in either case:
  - unimplemented address, or funct3 in {000, 100};
  - a write that would occur to an address with csr_address[11:10]==2'b11.
- A faulting request changes no state and returns rd_value=0.
- Write commit happens at the accept-cycle edge. Writing the low half replaces bits XLEN-1:0; writing the high half replaces bits COUNTER_WIDTH-1:XLEN. The other half is untouched.
- Counters:
  - mcycle increments every cycle.
  - minstret increments on each cycle with instret_pulse=1.
  - Both wrap from all-ones to 0 with no flag.
  - Same-cycle explicit write to any half of a counter: the write wins and there is no increment for that counter that cycle.
- Reset (asynchronous assert, synchronous release):
  - FSM to IDLE; csr_done=0, rd_value=0, illegal_access=0.
  - All CSRs and counters cleared to 0.
  - A request in flight is dropped and no response is produced.
- Outputs while csr_done=0: rd_value and illegal_access hold their last values. Consumers qualify them with csr_done.

Optional Feature:
- Macro: CSR_COUNTER_INHIBIT_EN.
- Defined:
  - Adds mcountinhibit at 0x320, RW. Only bits 0 (CY) and 2 (IR) are writable; all other bits read 0. Reset value 0.
  - CY=1 freezes mcycle; IR=1 freezes minstret. Explicit writes to a frozen counter still take effect.
- Undefined: 0x320 is unimplemented and illegal; counters always run.

Test Plan:
- Reset then CSRRW 0x340 with rs1=0xDEADBEEF; then CSRRS 0x340 with rs1_index=0 -> first response rd_value=0; second rd_value=0xDEADBEEF, no write; csr_done one cycle wide; csr_ready=0 during RESPOND.
- CSRRSI 0x7C1 with uimm=5, then CSRRCI 0x7C1 with uimm=1, then a read -> rd_values 0, 5, 4 in that order.
- Write mcycle=0xFFFFFFFE and mcycleh=0xFFFFFFFF, then read cycleh/cycle after 3 cycles -> the counter has wrapped through 0; the low half is small and the high half reads 0.
- CSRRW 0xC00 with rs1_index=3 -> illegal_access=1, rd_value=0, counter unaffected. CSRRS 0xC00 with rs1_index=0 -> legal read. Address 0x123 -> illegal.
- instret_pulse held high while CSRRW minstret=100 is accepted -> the next read equals 100 plus only the pulses after the write cycle.
- With CSR_COUNTER_INHIBIT_EN: write mcountinhibit=0x5, wait 10 cycles -> mcycle and minstret unchanged. Write 0 -> counting resumes. Assert reset mid-RESPOND -> no csr_done; all state reads 0 afterwards.
